// File: rtl/q4_sweep_checker.sv
// Exhaustive 4-input sweep driver and truth-table checker for a combinational block.
// Drives vectors 0..15, holds each HOLD_CYCLES cycles, captures e and scores against exp_tt.
module q4_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_tt,
  input  logic        e,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [3:0]       vec, vec_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TT_W-1:0]  exp_q, exp_n;
  logic [TT_W-1:0]  tt_n, tt_cap, diff;
  logic [3:0]       abcd_n;
  logic             busy_n, done_n, pass_n;
  logic [4:0]       mm_n, mm_calc;
  logic [3:0]       ff_n, ff_calc;

  // Table as it would look with the current vector's response folded in, and its score
  always_comb begin
    tt_cap      = tt;
    tt_cap[vec] = e;
    diff        = tt_cap ^ exp_q;
    mm_calc     = '0;
    ff_calc     = '0;
    for (int i = 0; i < 16; i++) begin
      mm_calc = mm_calc + 5'(diff[i]);
    end
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) ff_calc = 4'(i);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    exp_n   = exp_q;
    tt_n    = tt;
    abcd_n  = {a, b, c, d};
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    mm_n    = mismatch_cnt;
    ff_n    = first_fail;

    if (abort) begin
      state_n = S_IDLE;
      vec_n   = '0;
      cnt_n   = '0;
      tt_n    = '0;
      abcd_n  = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      pass_n  = 1'b0;
      mm_n    = '0;
      ff_n    = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_n = S_DRIVE;
            exp_n   = exp_tt;
            vec_n   = '0;
            cnt_n   = '0;
            tt_n    = '0;
            abcd_n  = '0;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            pass_n  = 1'b0;
            mm_n    = '0;
            ff_n    = '0;
          end
        end
        S_DRIVE: begin
          if (cnt == CNT_LAST) begin
            tt_n  = tt_cap;
            cnt_n = '0;
            if (vec == 4'd15) begin
              state_n = S_DONE;
              abcd_n  = '0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              pass_n  = (diff == '0);
              mm_n    = mm_calc;
              ff_n    = ff_calc;
            end else begin
              vec_n  = vec + 4'd1;
              abcd_n = vec + 4'd1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      vec          <= '0;
      cnt          <= '0;
      exp_q        <= '0;
      tt           <= '0;
      {a, b, c, d} <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
    end else begin
      state        <= state_n;
      vec          <= vec_n;
      cnt          <= cnt_n;
      exp_q        <= exp_n;
      tt           <= tt_n;
      {a, b, c, d} <= abcd_n;
      busy         <= busy_n;
      done         <= done_n;
      pass         <= pass_n;
      mismatch_cnt <= mm_n;
      first_fail   <= ff_n;
    end
  end

endmodule

// File: tb/tb_q4_sweep_checker.sv
// Bench for q4_sweep_checker: two instances (hold 2 and hold 1) driving a table-defined function block.
module tb_q4_sweep_checker;

  logic        clk = 1'b0;
  logic        rst, start, abort, sel;
  logic [15:0] exp_tt, fn_tt;
  int          checks = 0;
  int          errors = 0;

  logic        a2, b2, c2, d2, busy2, done2, pass2, e2, start2;
  logic        a1, b1, c1, d1, busy1, done1, pass1, e1, start1;
  logic [15:0] tt2, tt1;
  logic [4:0]  mm2, mm1;
  logic [3:0]  ff2, ff1;

  always #5 clk = ~clk;

  // Function block under test: e is looked up from the configured truth table
  assign e2     = fn_tt[{a2, b2, c2, d2}];
  assign e1     = fn_tt[{a1, b1, c1, d1}];
  assign start2 = start & ~sel;
  assign start1 = start & sel;

  q4_sweep_checker #(.HOLD_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .exp_tt(exp_tt), .e(e2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .tt(tt2), .mismatch_cnt(mm2), .first_fail(ff2));

  q4_sweep_checker #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .exp_tt(exp_tt), .e(e1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .tt(tt1), .mismatch_cnt(mm1), .first_fail(ff1));

  logic [3:0]  abcd_m, ff_m;
  logic        busy_m, done_m, pass_m;
  logic [15:0] tt_m;
  logic [4:0]  mm_m;
  assign abcd_m = sel ? {a1, b1, c1, d1} : {a2, b2, c2, d2};
  assign busy_m = sel ? busy1 : busy2;
  assign done_m = sel ? done1 : done2;
  assign pass_m = sel ? pass1 : pass2;
  assign tt_m   = sel ? tt1 : tt2;
  assign mm_m   = sel ? mm1 : mm2;
  assign ff_m   = sel ? ff1 : ff2;

  typedef struct {
    bit          s;
    logic [15:0] fn;
    logic [15:0] ex;
    bit          p;
    logic [4:0]  c;
    logic [3:0]  f;
    int          inj;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Full sweep: start, follow the vector sequence cycle by cycle, then score the DONE results
  task automatic run_sweep(input bit s, input logic [15:0] fn, input logic [15:0] ex,
                           input bit ep, input logic [4:0] ec, input logic [3:0] ef,
                           input int inj_k, input string nm);
    int h, bad;
    h      = s ? 1 : 2;
    sel    = s;
    fn_tt  = fn;
    exp_tt = ex;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    exp_tt = ~ex;
    chk({nm, "_clr_tt"}, 32'(tt_m), 32'h0);
    chk({nm, "_clr_res"}, 32'({done_m, pass_m, mm_m, ff_m}), 32'h0);
    bad = 0;
    for (int k = 0; k < 16 * h; k++) begin
      if (busy_m !== 1'b1 || done_m !== 1'b0 || abcd_m !== 4'(k / h)) bad++;
      if (k == inj_k) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({nm, "_seq"}, 32'(bad), 32'h0);
    chk({nm, "_done"}, 32'({done_m, busy_m}), 32'h2);
    chk({nm, "_abcd"}, 32'(abcd_m), 32'h0);
    chk({nm, "_tt"}, 32'(tt_m), 32'(fn));
    chk({nm, "_pass"}, 32'(pass_m), 32'(ep));
    chk({nm, "_mm"}, 32'(mm_m), 32'(ec));
    chk({nm, "_ff"}, 32'(ff_m), 32'(ef));
  endtask

  initial begin
    logic [15:0] fn, ex, df;
    logic [3:0]  ff;
    bit          s;
    int          mode;

    rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
    exp_tt = '0; fn_tt = '0;
    #1;
    chk("rst_u2", 32'({a2, b2, c2, d2, busy2, done2, pass2, tt2, mm2, ff2}), 32'h0);
    chk("rst_u1", 32'({a1, b1, c1, d1, busy1, done1, pass1, tt1, mm1, ff1}), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    tbl[0] = '{s: 1'b0, fn: 16'h6996, ex: 16'h6996, p: 1'b1, c: 5'd0,  f: 4'd0,  inj: -1};
    tbl[1] = '{s: 1'b0, fn: 16'h6996, ex: 16'h6916, p: 1'b0, c: 5'd1,  f: 4'd7,  inj: -1};
    tbl[2] = '{s: 1'b0, fn: 16'h0000, ex: 16'hFFFF, p: 1'b0, c: 5'd16, f: 4'd0,  inj: -1};
    tbl[3] = '{s: 1'b1, fn: 16'h8000, ex: 16'h8000, p: 1'b1, c: 5'd0,  f: 4'd0,  inj: 5};
    tbl[4] = '{s: 1'b1, fn: 16'h8000, ex: 16'h0000, p: 1'b0, c: 5'd1,  f: 4'd15, inj: -1};
    tbl[5] = '{s: 1'b0, fn: 16'h00F0, ex: 16'h0F00, p: 1'b0, c: 5'd8,  f: 4'd4,  inj: -1};
    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].s, tbl[i].fn, tbl[i].ex, tbl[i].p, tbl[i].c, tbl[i].f, tbl[i].inj,
                $sformatf("tbl%0d", i));
    end

    // Asynchronous reset in the middle of a cycle while vector 7 is driven
    sel = 1'b0; fn_tt = 16'h6996; exp_tt = 16'h6996;
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    chk("pre_rst_vec", 32'(abcd_m), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({abcd_m, busy_m, done_m, tt_m}), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", 32'({abcd_m, busy_m, done_m, tt_m}), 32'h0);
    end

    // Abort at vector 9 with start on the same edge
    start = 1'b1; tick(); start = 1'b0;
    repeat (18) tick();
    chk("pre_abort_vec", 32'(abcd_m), 32'h9);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_state", 32'({abcd_m, busy_m, done_m, pass_m, tt_m, mm_m, ff_m}), 32'h0);
    repeat (3) tick();
    chk("abort_idle", 32'({busy_m, done_m}), 32'h0);
    run_sweep(1'b0, 16'h6996, 16'h6996, 1'b1, 5'd0, 4'd0, -1, "post_abort");
    run_sweep(1'b0, 16'h1234, 16'h1234, 1'b1, 5'd0, 4'd0, -1, "restart_done");

    // Abort while in DONE
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_done", 32'({done_m, pass_m, tt_m}), 32'h0);

    // Random functions and expectations scored by a popcount / lowest-bit model
    for (int it = 0; it < 20; it++) begin
      s    = 1'($urandom_range(0, 1));
      fn   = 16'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      ex = fn;
      else if (mode == 1) ex = fn ^ (16'h1 << $urandom_range(0, 15));
      else                ex = 16'($urandom);
      df = fn ^ ex;
      ff = 4'd0;
      for (int i = 0; i < 16; i++) begin
        if (df[i]) begin
          ff = 4'(i);
          break;
        end
      end
      run_sweep(s, fn, ex, (df == 16'h0), 5'($countones(df)), ff, -1, $sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q4_sweep_checker.md
Name: q4_sweep_checker

Overview:
- Self-running stimulus and capture stage that sits directly upstream and downstream of the 4-input combinational function block (inputs a,b,c,d; output e).
- On a start pulse, the block drives all 16 input combinations in ascending order, holding each one for a programmable number of cycles.
- It samples e for every combination, builds a 16-bit truth table, and compares it against an expected table.
- It reports pass/fail, the mismatch count and the lowest failing index, replacing a hand-written exhaustive sweep with synthesizable hardware.

Parameters:
- HOLD_CYCLES, 20, cycles each input vector is held before e is sampled; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; honoured in IDLE or DONE only.
- abort  in  1  terminates a sweep in progress and returns to IDLE.
- exp_tt  in  16  expected truth table; bit i = expected e for vector i; latched on an accepted start.
- e  in  1  response from the function block under test.
- a  out  1  vector bit 3 (MSB).
- b  out  1  vector bit 2.
- c  out  1  vector bit 1.
- d  out  1  vector bit 0 (LSB).
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; result outputs are valid.
- pass  out  1  captured table equals latched exp_tt.
- tt  out  16  captured truth table; bit i = e sampled for vector i.
- mismatch_cnt  out  5  popcount(tt XOR exp_tt), range 0..16.
- first_fail  out  4  lowest i with a mismatch at bit i; 0 when pass=1.

Behaviour:
- Reset: one clock domain (clk); reset is asynchronous, active-high (rst). While rst=1, all outputs are forced to 0 immediately, independent of clk: a,b,c,d, busy, done, pass, tt, mismatch_cnt, first_fail. State is forced to IDLE, and the internal vec and cnt registers are cleared.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs a..d=0, busy=0.
  - start=1 at an edge: latch exp_tt, clear tt, set vec=0 and cnt=0, go to DRIVE, busy=1.
- DRIVE:
  - {a,b,c,d}=vec, registered.
  - Each edge: if cnt<HOLD_CYCLES-1, cnt increments.
  - On the edge where cnt==HOLD_CYCLES-1: tt[vec]<=e and cnt<=0.
    - If vec<15: vec increments.
    - If vec==15: go to DONE.
  - With HOLD_CYCLES=1, one vector is captured per edge; e is sampled in the same cycle the vector is driven.
- DONE entry (same edge as the vec=15 capture):
  - done=1, busy=0.
  - tt, pass, mismatch_cnt and first_fail are registered from the final table, including bit 15. All are valid in the first done cycle.
  - a..d return to 0.
- Latency: done rises exactly 16*HOLD_CYCLES edges after the start edge.
- DONE: results hold until the next start or abort. A start in DONE behaves as in IDLE: done, pass, mismatch_cnt, first_fail and tt clear on that edge.
- abort=1 in DRIVE or DONE: go to IDLE next edge, all outputs cleared. abort has priority over start and over a capture on the same edge.
- start while in DRIVE: ignored; exp_tt is not re-latched.
- start and abort are level-sampled, so holding start high through DONE causes a restart.
- first_fail encodes the lowest set bit of tt XOR exp_tt. mismatch_cnt is 5 bits so that 16 is representable.

Test Plan:
- HOLD_CYCLES=2, e=a^b^c^d, exp_tt=16'h6996, start pulse -> vectors 0..15 each driven 2 cycles; done at start+32 edges; tt=16'h6996, pass=1, mismatch_cnt=0, first_fail=0.
- Same DUT, exp_tt=16'h6916 -> pass=0, mismatch_cnt=1, first_fail=7, tt=16'h6996.
- e tied 0, exp_tt=16'hFFFF -> tt=16'h0000, mismatch_cnt=16, first_fail=0, pass=0.
- HOLD_CYCLES=1, e=a&b&c&d, exp_tt=16'h8000 -> done after 16 edges, pass=1; start pulse during DRIVE at vec=5 is ignored, with no restart and no latency change.
- Assert rst asynchronously mid-edge while vec=7 -> a..d, busy, tt all 0 before the next clk edge; after release, IDLE with no activity until start.
- Abort at vec=9 with start also high that cycle -> IDLE, done=0, tt=0; a subsequent start runs a full 16-vector sweep and restart from DONE clears done on the start edge.
